scan_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder with enable and an auto-scan mode. In direct mode it decodes the select input, registered, one cycle later. In scan mode it steps the active output through 0..last, holding each position for a programmable dwell, and flags each wrap. It drives row/digit strobes for multiplexed displays and keypads, replacing hand-instantiated fixed-width decoders.

---
 rtl/scan_decoder_pkg.sv | 18 +
 rtl/scan_decoder_if.sv | 33 +++
 rtl/scan_decoder_decoder_onehot.sv | 21 ++
 rtl/scan_decoder.sv | 91 +++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scan_decoder_pkg : shared state and mode encodings for scan_decoder    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_decoder_pkg
`default_nettype wire

// File: rtl/scan_decoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scan_decoder_if : control inputs and strobe outputs of scan_decoder    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface scan_decoder_if #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   i;
    logic               load;
    logic [SEL_W-1:0]   last;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   y;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, i, load, last, dwell,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, i, load, last, dwell,
        output y, idx, wrap
    );

endinterface : scan_decoder_if
`default_nettype wire

// File: rtl/scan_decoder_decoder_onehot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | decoder_onehot : combinational SEL_W -> 2**SEL_W decoder with enable   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module decoder_onehot #(
    parameter int SEL_W = 4
) (
    input  wire logic [SEL_W-1:0]        sel,
    input  wire logic                    en,
    output logic      [(1<<SEL_W)-1:0]   y
);
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule : decoder_onehot
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scan_decoder : registered one-hot decoder with direct and auto-scan    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    scan_decoder_if.slave  bus
);
    localparam int OUT_W = 1 << SEL_W;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic [OUT_W-1:0]   r_y;
    logic [OUT_W-1:0]   w_y_nxt;
    logic               w_y_en;

    // Next index/state are resolved first so y is decoded from the same
    // index that gets registered: y can never disagree with idx.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = '0;
        w_wrap_nxt  = 1'b0;
        if (!bus.en) begin
            w_state_nxt = IDLE;
        end else if (bus.mode == MODE_DIRECT) begin
            w_state_nxt = DIRECT;
            w_idx_nxt   = bus.i;
        end else if ((r_state != SCAN) || bus.load) begin
            w_state_nxt = SCAN;
            w_idx_nxt   = bus.i;
        end else begin
            w_state_nxt = SCAN;
            if (r_cnt >= bus.dwell) begin
                // Using >= lets an out-of-range index wrap on its first step.
                if (r_idx >= bus.last) begin
                    w_idx_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt  = r_idx + 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
        w_y_en = (w_state_nxt != IDLE);
    end

    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_decoder_onehot (
        .sel (w_idx_nxt),
        .en  (w_y_en),
        .y   (w_y_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign bus.y    = r_y;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;

endmodule : scan_decoder
`default_nettype wire
